taxi_eth_link_supervisor: RTL and testbench
===========================================

// Module: taxi_eth_link_supervisor
// PURPOSE
//  Single-lane link bring-up/recovery controller for the 25G transceiver+MAC quad wrapper.
//  Drives the wrapper's transceiver-control APB port to pulse the lane RX datapath reset.
//  Qualifies PCS status, reports link_up, and re-runs the reset sequence on timeout or link loss.
//  One instance per lane; instances share a control bus through an external APB arbiter.
// PARAMETERS
//  APB_ADDR_W       24        APB address width
//  APB_DATA_W       16        APB data width; pstrb width = APB_DATA_W/8
//  RST_ADDR         24'h0100  lane reset-control register address
//  RST_ASSERT_VAL   16'h0003  value written to assert the reset
//  RST_RELEASE_VAL  16'h0000  value written to release the reset
//  RST_HOLD_CYC     64        cycles the reset is held between the two writes
//  LOCK_STABLE_CYC  1024      consecutive qualified cycles required to declare link up
//  LOCK_TIMEOUT_CYC 1048576   maximum cycles in WAIT_LOCK before a retry
//  LOSS_CYC         16        consecutive unqualified cycles in UP that declare link loss
//  APB_TIMEOUT_CYC  256       maximum cycles waiting for pready
//  MAX_RETRY        7         consecutive failed attempts before FAIL
// PORTS
//  clk            in   1   clock, same domain as the wrapper's xcvr_ctrl_clk
//  rst_n          in   1   synchronous active-low reset
//  enable         in   1   run supervisor; 0 -> return to IDLE
//  rx_block_lock  in   1   PCS block lock, already synchronized to clk
//  rx_high_ber    in   1   PCS high BER, already synchronized to clk
//  rx_status      in   1   PCS RX status, already synchronized to clk
//  m_apb_paddr    out  24  APB address
//  m_apb_psel     out  1   APB select
//  m_apb_penable  out  1   APB enable
//  m_apb_pwrite   out  1   APB write; always 1
//  m_apb_pwdata   out  16  APB write data
//  m_apb_pstrb    out  2   APB strobes; all ones
//  m_apb_pready   in   1   APB ready
//  m_apb_pslverr  in   1   APB slave error
//  link_up        out  1   link qualified
//  fail           out  1   retries exhausted
//  apb_err        out  1   sticky; set by pslverr or APB timeout
//  state          out  3   current state encoding
//  retry_cnt      out  3   consecutive failed attempts
//  link_drop_cnt  out  16  link-loss events, saturating
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE and all outputs 0, including counters and apb_err.
//  Qualified cycle: q = rx_block_lock & rx_status & ~rx_high_ber.
//  States: IDLE=0, WR_ASSERT=1, HOLD=2, WR_RELEASE=3, WAIT_LOCK=4, UP=5, FAIL=6.
//  - IDLE: when enable=1, go to WR_ASSERT on the next cycle.
//  - WR_ASSERT / WR_RELEASE: one APB write each.
//    - Setup phase: psel=1, penable=0, one cycle. Access phase: psel=1, penable=1, held until pready=1.
//    - Write data: RST_ASSERT_VAL in WR_ASSERT, RST_RELEASE_VAL in WR_RELEASE.
//    - Outside a transfer, psel, penable and paddr are 0.
//    - APB error (pslverr=1 with pready=1, or APB_TIMEOUT_CYC access cycles without pready):
//      set apb_err, drop psel, count a failed attempt.
//    - Success: WR_ASSERT -> HOLD; WR_RELEASE -> WAIT_LOCK.
//  - HOLD: stay exactly RST_HOLD_CYC cycles, then go to WR_RELEASE.
//  - WAIT_LOCK:
//    - stable counter increments while q=1 and clears to 0 whenever q=0.
//    - When the counter reaches LOCK_STABLE_CYC: go to UP, link_up=1 on that transition, retry_cnt=0.
//    - After LOCK_TIMEOUT_CYC cycles in the state: failed attempt.
//    - Lock and timeout reached in the same cycle: lock wins.
//  - UP:
//    - loss counter increments while q=0 and clears to 0 whenever q=1.
//    - When it reaches LOSS_CYC: link_up=0 next cycle, link_drop_cnt+1 (saturates at 16'hFFFF),
//      go to WR_ASSERT. retry_cnt is unchanged.
//  - Failed attempt: if retry_cnt == MAX_RETRY-1, go to FAIL with fail=1 and retry_cnt=MAX_RETRY;
//    else retry_cnt+1 and go to WR_ASSERT.
//  - FAIL: hold. When enable=0: go to IDLE and clear fail and retry_cnt.
//  - enable=0 in any other state: go to IDLE; link_up=0 next cycle.
//    - An APB transfer in progress completes first; the drop takes effect on completion.
//    - apb_err and link_drop_cnt are cleared only by rst_n.
//  - State timers restart at 0 on every state entry.
//  - All outputs are registered. Worst-case link_up latency from enable:
//    2 APB writes + RST_HOLD_CYC + LOCK_STABLE_CYC + 2 cycles.
// TESTING
//  1. rst_n low 4 cycles, mid-transfer -> all outputs 0, psel=0, state=IDLE on the next edge.
//  2. enable=1, pready=1 always, q=1 from the release write -> writes 0x0003 then 0x0000 to 0x0100,
//     64 cycles apart; link_up rises 1024 cycles after the release write.
//  3. q stuck 0, LOCK_TIMEOUT_CYC=100 -> 7 reset sequences, then fail=1, retry_cnt=7, state=6;
//     enable=0 -> IDLE, fail=0.
//  4. In UP: q low for 15 cycles, then high -> stays up. q low for 16 cycles ->
//     link_up=0, link_drop_cnt=1, new assert write issued.
//  5. pready withheld 256 cycles -> apb_err=1, retry_cnt=1, sequence restarts.
//     pslverr on a write -> same response.
//  6. enable dropped during access phase with pready held off 10 cycles -> transfer completes,
//     then IDLE, no further APB traffic.

Source files
------------

// File: rtl/taxi_eth_link_supervisor_if.sv
// APB requester-side bundle between the link supervisor and the transceiver-control port.
// Latency: none, wires only.
// Backpressure: pready is driven by the completer and stalls the access phase.
interface taxi_eth_link_supervisor_if #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0]   paddr;
   logic                psel;
   logic                penable;
   logic                pwrite;
   logic [DATA_W-1:0]   pwdata;
   logic [DATA_W/8-1:0] pstrb;
   logic                pready;
   logic                pslverr;

   modport master (
      output paddr, psel, penable, pwrite, pwdata, pstrb,
      input  pready, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata, pstrb,
      output pready, pslverr
   );
endinterface

// File: rtl/taxi_eth_link_supervisor.sv
// Single-lane bring-up/recovery: pulses the lane RX reset over APB, qualifies PCS status, reports link_up.
// Latency: link_up at most 2 APB writes + RST_HOLD_CYC + LOCK_STABLE_CYC + 2 cycles after enable.
// Backpressure: the access phase holds until pready or APB_TIMEOUT_CYC; a transfer never aborts on enable=0.
module taxi_eth_link_supervisor #(
   parameter int                    APB_ADDR_W       = 24,
   parameter int                    APB_DATA_W       = 16,
   parameter logic [APB_ADDR_W-1:0] RST_ADDR         = 24'h000100,
   parameter logic [APB_DATA_W-1:0] RST_ASSERT_VAL   = 16'h0003,
   parameter logic [APB_DATA_W-1:0] RST_RELEASE_VAL  = 16'h0000,
   parameter int                    RST_HOLD_CYC     = 64,
   parameter int                    LOCK_STABLE_CYC  = 1024,
   parameter int                    LOCK_TIMEOUT_CYC = 1048576,
   parameter int                    LOSS_CYC         = 16,
   parameter int                    APB_TIMEOUT_CYC  = 256,
   parameter int                    MAX_RETRY        = 7
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              enable,
   input  logic                              rx_block_lock,
   input  logic                              rx_high_ber,
   input  logic                              rx_status,
   taxi_eth_link_supervisor_if.master        m_apb,
   output logic                              link_up,
   output logic                              fail,
   output logic                              apb_err,
   output logic [2:0]                        state,
   output logic [2:0]                        retry_cnt,
   output logic [15:0]                       link_drop_cnt
);

   localparam int TMR_MAX  = (LOCK_TIMEOUT_CYC > RST_HOLD_CYC)
                           ? ((LOCK_TIMEOUT_CYC > APB_TIMEOUT_CYC) ? LOCK_TIMEOUT_CYC : APB_TIMEOUT_CYC)
                           : ((RST_HOLD_CYC > APB_TIMEOUT_CYC) ? RST_HOLD_CYC : APB_TIMEOUT_CYC);
   localparam int TMR_W    = $clog2(TMR_MAX + 1);
   localparam int QCNT_MAX = (LOCK_STABLE_CYC > LOSS_CYC) ? LOCK_STABLE_CYC : LOSS_CYC;
   localparam int QCNT_W   = $clog2(QCNT_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WR_ASSERT  = 3'd1,
      ST_HOLD       = 3'd2,
      ST_WR_RELEASE = 3'd3,
      ST_WAIT_LOCK  = 3'd4,
      ST_UP         = 3'd5,
      ST_FAIL       = 3'd6
   } state_t;

   state_t                cur_state, nxt_state;
   logic [TMR_W-1:0]      timer, timer_nxt;
   logic [QCNT_W-1:0]     qcnt, qcnt_nxt;
   logic                  psel_reg, psel_nxt;
   logic                  penable_reg, penable_nxt;
   logic [APB_ADDR_W-1:0] paddr_reg, paddr_nxt;
   logic [APB_DATA_W-1:0] pwdata_reg, pwdata_nxt;
   logic                  link_up_nxt, fail_nxt, apb_err_nxt;
   logic [2:0]            retry_nxt;
   logic [15:0]           drop_nxt;
   logic                  enter;
   logic                  fail_attempt;
   logic                  q;

   // qualified PCS cycle: locked, status good, BER not high
   assign q = rx_block_lock & rx_status & ~rx_high_ber;

   assign m_apb.paddr   = paddr_reg;
   assign m_apb.psel    = psel_reg;
   assign m_apb.penable = penable_reg;
   assign m_apb.pwdata  = pwdata_reg;
   assign m_apb.pwrite  = 1'b1;
   assign m_apb.pstrb   = '1;
   assign state         = cur_state;

   // next-state, APB phase and status logic
   always_comb begin
      nxt_state    = cur_state;
      timer_nxt    = timer;
      qcnt_nxt     = qcnt;
      psel_nxt     = psel_reg;
      penable_nxt  = penable_reg;
      paddr_nxt    = paddr_reg;
      pwdata_nxt   = pwdata_reg;
      link_up_nxt  = link_up;
      fail_nxt     = fail;
      apb_err_nxt  = apb_err;
      retry_nxt    = retry_cnt;
      drop_nxt     = link_drop_cnt;
      enter        = 1'b0;
      fail_attempt = 1'b0;

      case (cur_state)
         ST_IDLE: begin
            if (enable) begin
               nxt_state  = ST_WR_ASSERT;
               enter      = 1'b1;
               psel_nxt   = 1'b1;
               paddr_nxt  = RST_ADDR;
               pwdata_nxt = RST_ASSERT_VAL;
            end
         end

         ST_WR_ASSERT, ST_WR_RELEASE: begin
            if (!psel_reg) begin
               // one idle cycle after a failed write before the retry's setup phase
               if (!enable) begin
                  nxt_state = ST_IDLE;
                  enter     = 1'b1;
               end else begin
                  psel_nxt    = 1'b1;
                  penable_nxt = 1'b0;
                  paddr_nxt   = RST_ADDR;
                  pwdata_nxt  = (cur_state == ST_WR_ASSERT) ? RST_ASSERT_VAL : RST_RELEASE_VAL;
               end
            end else if (!penable_reg) begin
               penable_nxt = 1'b1;
            end else if (m_apb.pready) begin
               psel_nxt    = 1'b0;
               penable_nxt = 1'b0;
               paddr_nxt   = '0;
               pwdata_nxt  = '0;
               if (m_apb.pslverr) begin
                  apb_err_nxt  = 1'b1;
                  fail_attempt = 1'b1;
               end else if (!enable) begin
                  nxt_state = ST_IDLE;
                  enter     = 1'b1;
               end else begin
                  nxt_state = (cur_state == ST_WR_ASSERT) ? ST_HOLD : ST_WAIT_LOCK;
                  enter     = 1'b1;
               end
            end else if (timer == TMR_W'(APB_TIMEOUT_CYC - 1)) begin
               psel_nxt     = 1'b0;
               penable_nxt  = 1'b0;
               paddr_nxt    = '0;
               pwdata_nxt   = '0;
               apb_err_nxt  = 1'b1;
               fail_attempt = 1'b1;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end

         ST_HOLD: begin
            if (!enable) begin
               nxt_state = ST_IDLE;
               enter     = 1'b1;
            end else if (timer == TMR_W'(RST_HOLD_CYC - 1)) begin
               nxt_state  = ST_WR_RELEASE;
               enter      = 1'b1;
               psel_nxt   = 1'b1;
               paddr_nxt  = RST_ADDR;
               pwdata_nxt = RST_RELEASE_VAL;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end

         ST_WAIT_LOCK: begin
            qcnt_nxt = q ? qcnt + 1'b1 : '0;
            if (!enable) begin
               nxt_state = ST_IDLE;
               enter     = 1'b1;
            end else if (q && qcnt == QCNT_W'(LOCK_STABLE_CYC - 1)) begin
               // lock beats a timeout landing on the same cycle
               nxt_state   = ST_UP;
               enter       = 1'b1;
               link_up_nxt = 1'b1;
               retry_nxt   = '0;
            end else if (timer == TMR_W'(LOCK_TIMEOUT_CYC - 1)) begin
               fail_attempt = 1'b1;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end

         ST_UP: begin
            if (!enable) begin
               nxt_state   = ST_IDLE;
               enter       = 1'b1;
               link_up_nxt = 1'b0;
            end else if (q) begin
               qcnt_nxt = '0;
            end else if (qcnt == QCNT_W'(LOSS_CYC - 1)) begin
               nxt_state   = ST_WR_ASSERT;
               enter       = 1'b1;
               link_up_nxt = 1'b0;
               drop_nxt    = (link_drop_cnt == 16'hFFFF) ? link_drop_cnt : link_drop_cnt + 16'd1;
               psel_nxt    = 1'b1;
               paddr_nxt   = RST_ADDR;
               pwdata_nxt  = RST_ASSERT_VAL;
            end else begin
               qcnt_nxt = qcnt + 1'b1;
            end
         end

         ST_FAIL: begin
            if (!enable) begin
               nxt_state = ST_IDLE;
               enter     = 1'b1;
               fail_nxt  = 1'b0;
               retry_nxt = '0;
            end
         end

         default: begin
            nxt_state = ST_IDLE;
            enter     = 1'b1;
         end
      endcase

      // a failed attempt either retries from the assert write or gives up
      if (fail_attempt) begin
         enter = 1'b1;
         if (retry_cnt == 3'(MAX_RETRY - 1)) begin
            nxt_state = ST_FAIL;
            fail_nxt  = 1'b1;
            retry_nxt = 3'(MAX_RETRY);
         end else begin
            retry_nxt = retry_cnt + 3'd1;
            nxt_state = enable ? ST_WR_ASSERT : ST_IDLE;
         end
      end

      if (enter) begin
         timer_nxt = '0;
         qcnt_nxt  = '0;
      end
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_state     <= ST_IDLE;
         timer         <= '0;
         qcnt          <= '0;
         psel_reg      <= 1'b0;
         penable_reg   <= 1'b0;
         paddr_reg     <= '0;
         pwdata_reg    <= '0;
         link_up       <= 1'b0;
         fail          <= 1'b0;
         apb_err       <= 1'b0;
         retry_cnt     <= '0;
         link_drop_cnt <= '0;
      end else begin
         cur_state     <= nxt_state;
         timer         <= timer_nxt;
         qcnt          <= qcnt_nxt;
         psel_reg      <= psel_nxt;
         penable_reg   <= penable_nxt;
         paddr_reg     <= paddr_nxt;
         pwdata_reg    <= pwdata_nxt;
         link_up       <= link_up_nxt;
         fail          <= fail_nxt;
         apb_err       <= apb_err_nxt;
         retry_cnt     <= retry_nxt;
         link_drop_cnt <= drop_nxt;
      end
   end

endmodule

// File: tb/tb_taxi_eth_link_supervisor.sv
// Directed bench for the link supervisor: bring-up, loss, APB errors, retries, enable drop, reset.
// Latency: expected cycle distances are hand-derived from the default parameters.
// Backpressure: pready is held off by the bench to exercise the access-phase stall and timeout.
module tb_taxi_eth_link_supervisor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable_a, enable_b;
   logic        rx_block_lock, rx_high_ber, rx_status;
   logic        link_up_a, fail_a, apb_err_a, link_up_b, fail_b, apb_err_b;
   logic [2:0]  state_a, retry_a, state_b, retry_b;
   logic [15:0] drop_a, drop_b;
   int          cyc = 0;
   int          n_chk = 0;
   int          n_err = 0;
   int          n_b_asrt = 0;
   int          n_b_rel = 0;

   taxi_eth_link_supervisor_if apb_a ();
   taxi_eth_link_supervisor_if apb_b ();

   assign apb_b.pready  = 1'b1;
   assign apb_b.pslverr = 1'b0;

   taxi_eth_link_supervisor dut_a (
      .clk(clk), .rst_n(rst_n), .enable(enable_a),
      .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber), .rx_status(rx_status),
      .m_apb(apb_a), .link_up(link_up_a), .fail(fail_a), .apb_err(apb_err_a),
      .state(state_a), .retry_cnt(retry_a), .link_drop_cnt(drop_a)
   );

   taxi_eth_link_supervisor #(.LOCK_TIMEOUT_CYC(100)) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(enable_b),
      .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber), .rx_status(rx_status),
      .m_apb(apb_b), .link_up(link_up_b), .fail(fail_b), .apb_err(apb_err_b),
      .state(state_b), .retry_cnt(retry_b), .link_drop_cnt(drop_b)
   );

   // free-running clock and edge counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // count write setup phases issued by the short-timeout instance
   always @(negedge clk) begin
      if (rst_n && apb_b.psel && !apb_b.penable) begin
         if (apb_b.pwdata == 16'h0003) n_b_asrt++;
         else                          n_b_rel++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_psel_a(input logic lvl, input int bound, input string tag);
      int k = 0;
      while (apb_a.psel !== lvl && k < bound) begin
         @(negedge clk);
         k++;
      end
      chk(tag, apb_a.psel, lvl);
   endtask

   task automatic wait_link_a(input int bound, input string tag);
      int k = 0;
      while (link_up_a !== 1'b1 && k < bound) begin
         @(negedge clk);
         k++;
      end
      chk(tag, link_up_a, 1'b1);
   endtask

   initial begin
      int c0, c1, c2, c3, k;
      rst_n         = 1'b0;
      enable_a      = 1'b0;
      enable_b      = 1'b0;
      rx_block_lock = 1'b0;
      rx_status     = 1'b0;
      rx_high_ber   = 1'b0;
      apb_a.pready  = 1'b1;
      apb_a.pslverr = 1'b0;
      repeat (4) @(negedge clk);

      // power-on reset values
      chk("rst_state", state_a, 0);
      chk("rst_psel", apb_a.psel, 0);
      chk("rst_link_up", link_up_a, 0);
      chk("rst_apb_err", apb_err_a, 0);
      chk("rst_drop", drop_a, 0);
      chk("rst_state_b", state_b, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // bring-up: assert write, 64-cycle hold, release write, 1024 qualified cycles
      enable_a = 1'b1;
      wait_psel_a(1'b1, 10, "asrt_setup_seen");
      chk("asrt_state", state_a, 1);
      chk("asrt_addr", apb_a.paddr, 32'h100);
      chk("asrt_data", apb_a.pwdata, 32'h3);
      chk("asrt_penable", apb_a.penable, 0);
      chk("asrt_pwrite", apb_a.pwrite, 1);
      chk("asrt_pstrb", apb_a.pstrb, 2'b11);
      wait_psel_a(1'b0, 10, "asrt_done_seen");
      c0 = cyc;
      chk("hold_state", state_a, 2);
      wait_psel_a(1'b1, 100, "rel_setup_seen");
      c1 = cyc;
      chk("hold_gap", c1 - c0, 64);
      chk("rel_state", state_a, 3);
      chk("rel_addr", apb_a.paddr, 32'h100);
      chk("rel_data", apb_a.pwdata, 32'h0);
      rx_block_lock = 1'b1;
      rx_status     = 1'b1;
      wait_psel_a(1'b0, 10, "rel_done_seen");
      c2 = cyc;
      chk("wait_lock_state", state_a, 4);
      wait_link_a(1100, "link_up_seen");
      c3 = cyc;
      chk("lock_latency", c3 - c2, 1024);
      chk("up_state", state_a, 5);
      chk("up_retry", retry_a, 0);

      // loss filter: 15 bad cycles tolerated, 16 declare loss
      rx_high_ber = 1'b1;
      repeat (15) @(negedge clk);
      rx_high_ber = 1'b0;
      repeat (3) @(negedge clk);
      chk("glitch15_link", link_up_a, 1);
      chk("glitch15_state", state_a, 5);
      chk("glitch15_drop", drop_a, 0);
      rx_status = 1'b0;
      repeat (16) @(negedge clk);
      chk("loss16_link", link_up_a, 0);
      chk("loss16_drop", drop_a, 1);
      chk("loss16_state", state_a, 1);
      chk("loss16_psel", apb_a.psel, 1);
      chk("loss16_data", apb_a.pwdata, 32'h3);

      // APB timeout: pready withheld, error after exactly 256 access cycles
      apb_a.pready = 1'b0;
      k = 0;
      while (apb_a.psel && k < 400) begin
         @(negedge clk);
         if (apb_a.psel && apb_a.penable) k++;
      end
      chk("to_access_cycles", k, 256);
      chk("to_psel_dropped", apb_a.psel, 0);
      chk("to_apb_err", apb_err_a, 1);
      chk("to_retry", retry_a, 1);
      chk("to_state", state_a, 1);
      @(negedge clk);
      chk("to_restart_psel", apb_a.psel, 1);
      chk("to_restart_pen", apb_a.penable, 0);
      chk("to_restart_data", apb_a.pwdata, 32'h3);

      // slave error on the retried write
      apb_a.pready  = 1'b1;
      apb_a.pslverr = 1'b1;
      repeat (2) @(negedge clk);
      apb_a.pslverr = 1'b0;
      chk("slverr_psel", apb_a.psel, 0);
      chk("slverr_retry", retry_a, 2);
      chk("slverr_apb_err", apb_err_a, 1);
      chk("slverr_state", state_a, 1);
      rx_status = 1'b1;
      wait_link_a(1300, "relock_seen");
      chk("relock_retry", retry_a, 0);
      chk("relock_drop", drop_a, 1);

      // enable dropped mid-access: transfer completes, then IDLE and silence
      rx_block_lock = 1'b0;
      repeat (16) @(negedge clk);
      chk("loss2_drop", drop_a, 2);
      apb_a.pready = 1'b0;
      @(negedge clk);
      enable_a = 1'b0;
      repeat (9) @(negedge clk);
      chk("endrop_still_busy_state", state_a, 1);
      chk("endrop_still_busy_pen", apb_a.penable, 1);
      apb_a.pready = 1'b1;
      @(negedge clk);
      chk("endrop_idle_state", state_a, 0);
      chk("endrop_psel", apb_a.psel, 0);
      chk("endrop_link", link_up_a, 0);
      k = 0;
      repeat (50) begin
         @(negedge clk);
         if (apb_a.psel) k++;
      end
      chk("endrop_no_traffic", k, 0);
      chk("endrop_apb_err_sticky", apb_err_a, 1);

      // retry exhaustion on the short-timeout instance with q stuck low
      enable_b = 1'b1;
      k = 0;
      while (fail_b !== 1'b1 && k < 1500) begin
         @(negedge clk);
         k++;
      end
      chk("exhaust_fail", fail_b, 1);
      chk("exhaust_retry", retry_b, 7);
      chk("exhaust_state", state_b, 6);
      chk("exhaust_asrt_writes", n_b_asrt, 7);
      chk("exhaust_rel_writes", n_b_rel, 7);
      repeat (5) @(negedge clk);
      chk("fail_hold_state", state_b, 6);
      chk("fail_hold_psel", apb_b.psel, 0);
      enable_b = 1'b0;
      @(negedge clk);
      chk("fail_clear_state", state_b, 0);
      chk("fail_clear_fail", fail_b, 0);
      chk("fail_clear_retry", retry_b, 0);

      // synchronous reset in the middle of an access phase
      enable_a     = 1'b1;
      apb_a.pready = 1'b0;
      wait_psel_a(1'b1, 10, "midrst_setup_seen");
      @(negedge clk);
      chk("midrst_in_access", apb_a.penable, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_state", state_a, 0);
      chk("midrst_psel", apb_a.psel, 0);
      chk("midrst_penable", apb_a.penable, 0);
      chk("midrst_paddr", apb_a.paddr, 0);
      chk("midrst_apb_err", apb_err_a, 0);
      chk("midrst_drop", drop_a, 0);
      chk("midrst_link", link_up_a, 0);
      chk("midrst_fail", fail_a, 0);
      repeat (3) @(negedge clk);
      chk("midrst_psel_held", apb_a.psel, 0);
      rst_n    = 1'b1;
      enable_a = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
